// File: rtl/div_result_bcd_if.sv
// Result bus between divider_8bit and the BCD result stage.
// The divider side drives the result; the BCD stage drives the digits and status.
interface div_result_bcd_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  idle;
   logic                  not_valid;
   logic [WIDTH-1:0]      quotient;
   logic [WIDTH-1:0]      remainder;
   logic [4*DIGITS-1:0]   bcd_quot;
   logic [4*DIGITS-1:0]   bcd_rem;
   logic                  err;
   logic                  busy;
   logic                  done;

   modport master (
      output idle, not_valid, quotient, remainder,
      input  bcd_quot, bcd_rem, err, busy, done
   );

   modport slave (
      input  idle, not_valid, quotient, remainder,
      output bcd_quot, bcd_rem, err, busy, done
   );
endinterface

// File: rtl/div_result_bcd.sv
// Captures a divider result on the rising edge of idle and converts quotient and
// remainder to packed BCD with a sequential double dabble; digits held until next result.
module div_result_bcd #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   div_result_bcd_if.slave       bus
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic             idle_dly_q;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic [WIDTH-1:0] qbin_q,      qbin_d;
   logic [WIDTH-1:0] rbin_q,      rbin_d;
   logic [BW-1:0]    qacc_q,      qacc_d;
   logic [BW-1:0]    racc_q,      racc_d;
   logic             inv_q,       inv_d;
   logic [BW-1:0]    bcd_quot_q,  bcd_quot_d;
   logic [BW-1:0]    bcd_rem_q,   bcd_rem_d;
   logic             err_q,       err_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic             trigger_s;

   // Double dabble correction: every digit of 5 or more gets +3 before the shift.
   function automatic logic [BW-1:0] add3(input logic [BW-1:0] acc);
      logic [BW-1:0] res;
      res = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end else begin
            res[4*i +: 4] = acc[4*i +: 4];
         end
      end
      return res;
   endfunction

   assign trigger_s = bus.idle & ~idle_dly_q;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      qbin_d     = qbin_q;
      rbin_d     = rbin_q;
      qacc_d     = qacc_q;
      racc_d     = racc_q;
      inv_d      = inv_q;
      bcd_quot_d = bcd_quot_q;
      bcd_rem_d  = bcd_rem_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (trigger_s) begin
               qbin_d  = bus.quotient;
               rbin_d  = bus.remainder;
               inv_d   = bus.not_valid;
               qacc_d  = {BW{1'b0}};
               racc_d  = {BW{1'b0}};
               cnt_d   = {CW{1'b0}};
               state_d = S_CONV;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CONV: begin
            // An invalid result spends one cycle here so done follows two edges after the trigger.
            if (inv_q) begin
               bcd_quot_d = {BW{1'b1}};
               bcd_rem_d  = {BW{1'b1}};
               err_d      = 1'b1;
               state_d    = S_DONE;
            end else begin
               qacc_d = (add3(qacc_q) << 1) | {{(BW-1){1'b0}}, qbin_q[WIDTH-1]};
               racc_d = (add3(racc_q) << 1) | {{(BW-1){1'b0}}, rbin_q[WIDTH-1]};
               qbin_d = qbin_q << 1;
               rbin_d = rbin_q << 1;
               cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_q == CW'(WIDTH - 1)) begin
                  bcd_quot_d = qacc_d;
                  bcd_rem_d  = racc_d;
                  err_d      = 1'b0;
                  state_d    = S_DONE;
               end else begin
                  state_d = S_CONV;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; idle_dly resets high so a held idle never triggers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idle_dly_q <= 1'b1;
         cnt_q      <= {CW{1'b0}};
         qbin_q     <= {WIDTH{1'b0}};
         rbin_q     <= {WIDTH{1'b0}};
         qacc_q     <= {BW{1'b0}};
         racc_q     <= {BW{1'b0}};
         inv_q      <= 1'b0;
         bcd_quot_q <= {BW{1'b0}};
         bcd_rem_q  <= {BW{1'b0}};
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idle_dly_q <= bus.idle;
         cnt_q      <= cnt_d;
         qbin_q     <= qbin_d;
         rbin_q     <= rbin_d;
         qacc_q     <= qacc_d;
         racc_q     <= racc_d;
         inv_q      <= inv_d;
         bcd_quot_q <= bcd_quot_d;
         bcd_rem_q  <= bcd_rem_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.bcd_quot = bcd_quot_q;
   assign bus.bcd_rem  = bcd_rem_q;
   assign bus.err      = err_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd: directed scenarios plus random results
// compared against a decimal-arithmetic reference model.
module tb_div_result_bcd;
   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   div_result_bcd_if #(.WIDTH(8), .DIGITS(3)) bus ();

   div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] b;
      b[11:8] = 4'((v / 100) % 10);
      b[7:4]  = 4'((v / 10) % 10);
      b[3:0]  = 4'(v % 10);
      return b;
   endfunction

   // Presents one result with an idle rise and observes 16 edges from the sampling edge.
   task automatic run_result(input logic [7:0] q, input logic [7:0] r, input logic nv,
                             output int lat, output int ndone, output int nbusy,
                             output logic [11:0] bq, output logic [11:0] br, output logic e);
      @(negedge clk);
      bus.idle = 1'b0;
      @(negedge clk);
      bus.quotient  = q;
      bus.remainder = r;
      bus.not_valid = nv;
      bus.idle      = 1'b1;
      lat = 0; ndone = 0; nbusy = 0;
      bq = 12'hxxx; br = 12'hxxx; e = 1'bx;
      for (int n = 1; n <= 16; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) begin
            bus.quotient  = 8'($urandom);
            bus.remainder = 8'($urandom);
         end
         if (bus.done === 1'b1) begin
            ndone++;
            if (lat == 0) begin
               lat = n;
               bq  = bus.bcd_quot;
               br  = bus.bcd_rem;
               e   = bus.err;
            end
         end
         if (bus.busy === 1'b1) nbusy++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.idle = 1'b1; bus.not_valid = 1'b0; bus.quotient = 8'd0; bus.remainder = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({bus.bcd_quot, bus.bcd_rem, bus.err, bus.busy, bus.done} !== 27'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got q=%h r=%h err=%b busy=%b done=%b, want all 0",
                  bus.bcd_quot, bus.bcd_rem, bus.err, bus.busy, bus.done);
      end
   endtask

   task automatic test_idle_held();
      int seen;
      seen = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         if (bus.done !== 1'b0 || bus.bcd_quot !== 12'h000 || bus.bcd_rem !== 12'h000) seen++;
      end
      tests_run++;
      if (seen != 0) begin
         tests_failed++;
         $display("FAIL idle_held: %0d cycles with done or nonzero output, want 0", seen);
      end
   endtask

   task automatic test_conversion();
      int lat, nd, nb;
      logic [11:0] bq, br;
      logic e;
      int qv[3] = '{28, 255, 0};
      int rv[3] = '{4, 0, 99};
      for (int i = 0; i < 3; i++) begin
         run_result(8'(qv[i]), 8'(rv[i]), 1'b0, lat, nd, nb, bq, br, e);
         tests_run++;
         if (lat != 9 || nd != 1 || nb != 9) begin
            tests_failed++;
            $display("FAIL conv_timing q=%0d: lat=%0d done=%0d busy=%0d, want 9/1/9", qv[i], lat, nd, nb);
         end
         tests_run++;
         if (bq !== to_bcd(qv[i]) || br !== to_bcd(rv[i]) || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL conv_value q=%0d r=%0d: got %h/%h err=%b, want %h/%h err=0",
                     qv[i], rv[i], bq, br, e, to_bcd(qv[i]), to_bcd(rv[i]));
         end
      end
   endtask

   task automatic test_invalid();
      int lat, nd, nb;
      logic [11:0] bq, br;
      logic e;
      run_result(8'd17, 8'd3, 1'b1, lat, nd, nb, bq, br, e);
      tests_run++;
      if (lat != 2 || nd != 1 || nb != 2) begin
         tests_failed++;
         $display("FAIL invalid_timing: lat=%0d done=%0d busy=%0d, want 2/1/2", lat, nd, nb);
      end
      tests_run++;
      if (bq !== 12'hFFF || br !== 12'hFFF || e !== 1'b1) begin
         tests_failed++;
         $display("FAIL invalid_value: got %h/%h err=%b, want FFF/FFF err=1", bq, br, e);
      end
      run_result(8'd5, 8'd1, 1'b0, lat, nd, nb, bq, br, e);
      tests_run++;
      if (bq !== 12'h005 || br !== 12'h001 || e !== 1'b0 || lat != 9) begin
         tests_failed++;
         $display("FAIL after_invalid: got %h/%h err=%b lat=%0d, want 005/001 err=0 lat=9", bq, br, e, lat);
      end
   endtask

   task automatic test_reset_mid_conv();
      int lat, nd, nb;
      logic [11:0] bq, br;
      logic e;
      @(negedge clk);
      bus.idle = 1'b0;
      @(negedge clk);
      bus.quotient = 8'd128; bus.remainder = 8'd7; bus.not_valid = 1'b0; bus.idle = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({bus.bcd_quot, bus.bcd_rem, bus.err, bus.busy, bus.done} !== 27'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_conv: got q=%h r=%h err=%b busy=%b done=%b, want all 0",
                  bus.bcd_quot, bus.bcd_rem, bus.err, bus.busy, bus.done);
      end
      @(negedge clk);
      rst = 1'b0;
      run_result(8'd128, 8'd7, 1'b0, lat, nd, nb, bq, br, e);
      tests_run++;
      if (bq !== 12'h128 || br !== 12'h007 || lat != 9 || nd != 1) begin
         tests_failed++;
         $display("FAIL after_reset_conv: got %h/%h lat=%0d done=%0d, want 128/007 lat=9 done=1", bq, br, lat, nd);
      end
   endtask

   task automatic test_glitch();
      int lat, nd;
      logic [11:0] bq;
      @(negedge clk);
      bus.idle = 1'b0;
      @(negedge clk);
      bus.quotient = 8'd28; bus.remainder = 8'd4; bus.not_valid = 1'b0; bus.idle = 1'b1;
      lat = 0; nd = 0; bq = 12'hxxx;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (n == 3) begin
            bus.idle = 1'b0;
            bus.quotient = 8'd99;
         end
         if (n == 4) bus.idle = 1'b1;
         if (bus.done === 1'b1) begin
            nd++;
            if (lat == 0) begin
               lat = n;
               bq  = bus.bcd_quot;
            end
         end
      end
      tests_run++;
      if (nd != 1 || lat != 9 || bq !== 12'h028) begin
         tests_failed++;
         $display("FAIL glitch: done=%0d lat=%0d q=%h, want 1/9/028", nd, lat, bq);
      end
   endtask

   task automatic test_random();
      int lat, nd, nb;
      logic [11:0] bq, br, eq, er;
      logic e, nv;
      logic [7:0] q, r;
      for (int i = 0; i < 20; i++) begin
         q  = 8'($urandom);
         r  = 8'($urandom);
         nv = ($urandom_range(0, 3) == 0);
         eq = nv ? 12'hFFF : to_bcd(int'(q));
         er = nv ? 12'hFFF : to_bcd(int'(r));
         run_result(q, r, nv, lat, nd, nb, bq, br, e);
         tests_run++;
         if (bq !== eq || br !== er || e !== nv || nd != 1 || lat != (nv ? 2 : 9)) begin
            tests_failed++;
            $display("FAIL random q=%0d r=%0d nv=%b: got %h/%h err=%b lat=%0d done=%0d, want %h/%h err=%b",
                     q, r, nv, bq, br, e, lat, nd, eq, er, nv);
         end
         tests_run++;
         if (bus.bcd_quot !== eq || bus.bcd_rem !== er || bus.err !== nv) begin
            tests_failed++;
            $display("FAIL hold q=%0d r=%0d: got %h/%h err=%b, want %h/%h err=%b",
                     q, r, bus.bcd_quot, bus.bcd_rem, bus.err, eq, er, nv);
         end
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_idle_held();
      test_conversion();
      test_invalid();
      test_reset_mid_conv();
      test_glitch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
